// File: rtl/fifo_push_arbiter_pkg.sv
// Shared types and helpers for the FIFO push arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    // Tag width for n requesters; never below one bit.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Low bit of requester idx within a flat bus of w-bit lanes.
    function automatic int lane_lsb(input int idx, input int w);
        return idx * w;
    endfunction

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after i_ptr, scanning modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic [ID_WIDTH-1:0] i_ptr,
    output logic [NUM_REQ-1:0]  o_gnt,
    output logic [ID_WIDTH-1:0] o_idx,
    output logic                o_any
);

    logic [NUM_REQ-1:0]  w_rot;
    logic [ID_WIDTH-1:0] w_src;
    int                  w_first;

    always_comb begin
        w_rot   = '0;
        w_src   = '0;
        w_first = 0;
        o_gnt   = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_src    = ID_WIDTH'((k + int'(i_ptr)) % NUM_REQ);
            w_rot[k] = i_req[w_src];
        end
        // Descending scan so the lowest rotated position is left in w_first.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_first = k;
                o_any   = 1'b1;
            end
        end
        if (o_any) begin
            o_idx        = ID_WIDTH'((w_first + int'(i_ptr)) % NUM_REQ);
            o_gnt[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO write port; registered push tagged with the winner id.
// Optional burst lock enabled by defining FIFO_PUSH_ARBITER_LOCK_EN.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REQ      = 4,
    parameter int FIFO_LENGTH  = 16,
    parameter int COUNTER_SIZE = $clog2(FIFO_LENGTH + 1),
    parameter int ID_WIDTH     = id_width(NUM_REQ),
    parameter int MAX_BURST    = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [NUM_REQ-1:0]             i_req_lock,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_data,
    output logic [NUM_REQ-1:0]             o_req_ready,
    input  logic [COUNTER_SIZE-1:0]        i_fifo_count,
    output logic                           o_fifo_push,
    output logic [ID_WIDTH+DATA_WIDTH-1:0] o_fifo_data,
    output logic [ID_WIDTH-1:0]            o_grant_id
);

    logic                           r_fifo_push;
    logic [ID_WIDTH+DATA_WIDTH-1:0] r_fifo_data;
    logic [ID_WIDTH-1:0]            r_grant_id;
    logic [ID_WIDTH-1:0]            r_prio_ptr;
    logic [ID_WIDTH-1:0]            w_prio_ptr_nxt;

    logic [COUNTER_SIZE:0]  w_level;
    logic                   w_space_ok;
    logic [NUM_REQ-1:0]     w_elig;
    logic [NUM_REQ-1:0]     w_gnt;
    logic [ID_WIDTH-1:0]    w_win;
    logic [ID_WIDTH-1:0]    w_win_inc;
    logic                   w_any;
    logic                   w_beat;
    logic [DATA_WIDTH-1:0]  w_win_data;

    // Our own registered push is not yet in fifo_count, so it is added here.
    assign w_level    = {1'b0, i_fifo_count} + {{COUNTER_SIZE{1'b0}}, r_fifo_push};
    assign w_space_ok = w_level < (COUNTER_SIZE+1)'(FIFO_LENGTH);

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .i_req (w_elig),
        .i_ptr (r_prio_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_win),
        .o_any (w_any)
    );

    assign w_beat      = w_space_ok & w_any;
    assign o_req_ready = w_space_ok ? w_gnt : '0;
    assign w_win_inc   = ID_WIDTH'(wrap_inc(int'(w_win), NUM_REQ));
    assign w_win_data  = i_req_data[lane_lsb(int'(w_win), DATA_WIDTH) +: DATA_WIDTH];

`ifdef FIFO_PUSH_ARBITER_LOCK_EN
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_e          r_state, w_state_nxt;
    logic [BW-1:0]       r_burst_cnt, w_burst_nxt;
    logic [ID_WIDTH-1:0] r_lock_id, w_lock_id_nxt;
    logic                w_hold;

    // The lock holder keeps the port only while it presents both valid and lock.
    assign w_hold = (r_state == ST_LOCK) & i_req_valid[r_lock_id] & i_req_lock[r_lock_id];
    assign w_elig = (r_state == ST_ARB) ? i_req_valid
                  : (w_hold ? (NUM_REQ'(1) << r_lock_id) : '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_ARB;
            r_burst_cnt <= '0;
            r_lock_id   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_lock_id   <= w_lock_id_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_burst_nxt    = r_burst_cnt;
        w_lock_id_nxt  = r_lock_id;
        w_prio_ptr_nxt = w_beat ? w_win_inc : r_prio_ptr;
        case (r_state)
            ST_ARB: begin
                if (w_beat && i_req_lock[w_win] && MAX_BURST > 1) begin
                    w_state_nxt   = ST_LOCK;
                    w_burst_nxt   = BW'(1);
                    w_lock_id_nxt = w_win;
                end
            end
            ST_LOCK: begin
                if (!w_hold) begin
                    w_state_nxt    = ST_ARB;
                    w_burst_nxt    = '0;
                    w_prio_ptr_nxt = ID_WIDTH'(wrap_inc(int'(r_lock_id), NUM_REQ));
                end else if (w_beat) begin
                    if (r_burst_cnt + BW'(1) >= BW'(MAX_BURST)) begin
                        w_state_nxt = ST_ARB;
                        w_burst_nxt = '0;
                    end else begin
                        w_burst_nxt = r_burst_cnt + BW'(1);
                    end
                end
            end
            default: w_state_nxt = ST_ARB;
        endcase
    end
`else
    logic w_unused_lock;

    assign w_unused_lock  = ^i_req_lock;
    assign w_elig         = i_req_valid;
    assign w_prio_ptr_nxt = w_beat ? w_win_inc : r_prio_ptr;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fifo_push <= 1'b0;
            r_fifo_data <= '0;
            r_grant_id  <= '0;
            r_prio_ptr  <= '0;
        end else begin
            r_fifo_push <= w_beat;
            r_prio_ptr  <= w_prio_ptr_nxt;
            if (w_beat) begin
                r_fifo_data <= {w_win, w_win_data};
                r_grant_id  <= w_win;
            end
        end
    end

    assign o_fifo_push = r_fifo_push;
    assign o_fifo_data = r_fifo_data;
    assign o_grant_id  = r_grant_id;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Randomised bench for fifo_push_arbiter against a queue/arithmetic reference with a FIFO level model.
module tb_fifo_push_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int FL = 4;
    localparam int CS = 3;
    localparam int IW = 2;
    localparam int MB = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_lock;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic [CS-1:0]     fifo_count;
    logic              fifo_push;
    logic [IW+DW-1:0]  fifo_data;
    logic [IW-1:0]     grant_id;

    always #5 clk = ~clk;

    fifo_push_arbiter #(
        .DATA_WIDTH  (DW),
        .NUM_REQ     (NR),
        .FIFO_LENGTH (FL),
        .MAX_BURST   (MB)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .i_req_lock   (req_lock),
        .i_req_data   (req_data),
        .o_req_ready  (req_ready),
        .i_fifo_count (fifo_count),
        .o_fifo_push  (fifo_push),
        .o_fifo_data  (fifo_data),
        .o_grant_id   (grant_id)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: FIFO occupancy, priority pointer, pending push, lock bookkeeping.
    int              occ, ptr, m_lid, m_burst;
    bit              m_push, m_locked;
    logic [IW-1:0]   m_id;
    logic [DW-1:0]   m_pay;
    logic [DW-1:0]   dat [NR];
    int              ids[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        occ = 0; ptr = 0; m_lid = 0; m_burst = 0;
        m_push = 0; m_locked = 0; m_id = '0; m_pay = '0;
    endtask

    task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] lk, input bit drop);
        logic [NR-1:0] elig, exp_rdy;
        bit            space, beat, exit_now;
        int            win, j;
        for (int i = 0; i < NR; i++) begin
            dat[i] = DW'($urandom);
            req_data[i*DW +: DW] = dat[i];
        end
        req_valid  = v;
        req_lock   = lk;
        fifo_count = CS'(occ);
        #1;
        exit_now = 0;
`ifdef FIFO_PUSH_ARBITER_LOCK_EN
        if (m_locked) begin
            if (v[m_lid] && lk[m_lid]) elig = NR'(1) << m_lid;
            else begin elig = '0; exit_now = 1; end
        end else elig = v;
`else
        elig = v;
`endif
        space = (occ + int'(m_push)) < FL;
        win = -1;
        if (space)
            for (int k = 0; k < NR; k++) begin
                j = (ptr + k) % NR;
                if (elig[j] && win < 0) win = j;
            end
        beat    = (win >= 0);
        exp_rdy = beat ? (NR'(1) << win) : '0;
        chk("ready", req_ready, exp_rdy);
        @(posedge clk);
        #1;
        if (drop && occ > 0) occ--;
        occ += int'(m_push);
        m_push = beat;
        if (beat) begin
            m_id  = IW'(win);
            m_pay = dat[win];
            ids.push_back(win);
        end
        if (exit_now) begin
            m_locked = 0;
            ptr = (m_lid + 1) % NR;
        end else if (beat) begin
            ptr = (win + 1) % NR;
`ifdef FIFO_PUSH_ARBITER_LOCK_EN
            if (m_locked) begin
                m_burst++;
                if (m_burst >= MB) m_locked = 0;
            end else if (lk[win] && MB > 1) begin
                m_locked = 1; m_lid = win; m_burst = 1;
            end
`endif
        end
        chk("push",  fifo_push, m_push);
        chk("data",  fifo_data, {m_id, m_pay});
        chk("grant", grant_id,  m_id);
    endtask

    task automatic chk_ids(input string tag, input int exp[$]);
        chk({tag, "_len"}, ids.size(), exp.size());
        for (int i = 0; i < exp.size() && i < ids.size(); i++)
            chk(tag, ids[i], exp[i]);
    endtask

    int n_before;

    initial begin
        rst = 1'b1; req_valid = '0; req_lock = '0; req_data = '0; fifo_count = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_push",  fifo_push, 0);
        chk("rst_data",  fifo_data, 0);
        chk("rst_grant", grant_id,  0);
        chk("rst_ready", req_ready, 0);
        @(negedge clk) rst = 1'b0;

        // All valid, drained every cycle: plain rotation.
        ids.delete();
        repeat (5) step(4'hF, 4'h0, 1'b1);
        chk_ids("rot", '{0, 1, 2, 3, 0});

        // Lone req2, then req1 and req3 together.
        ids.delete();
        step(4'b0100, 4'h0, 1'b1);
        step(4'b1010, 4'h0, 1'b1);
        step(4'b1010, 4'h0, 1'b1);
        chk_ids("skip", '{2, 3, 1});

        // Fill without drops, then a single drop admits exactly one more beat.
        repeat (6) step(4'h0, 4'h0, 1'b1);
        ids.delete();
        repeat (8) step(4'hF, 4'h0, 1'b0);
        chk("fill_beats", ids.size(), 4);
        step(4'hF, 4'h0, 1'b1);
        repeat (4) step(4'hF, 4'h0, 1'b0);
        chk("drop_beats", ids.size(), 5);

        // Asynchronous reset while a push is in flight.
        repeat (6) step(4'h0, 4'h0, 1'b1);
        repeat (2) step(4'hF, 4'h0, 1'b1);
        chk("pre_rst_push", fifo_push, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_push",  fifo_push, 0);
        chk("arst_grant", grant_id,  0);
        model_reset();
        req_valid = 4'hF; fifo_count = '0;
        #1;
        chk("arst_ptr", req_ready, 4'b0001);
        @(negedge clk) rst = 1'b0;
        ids.delete();
        step(4'hF, 4'h0, 1'b1);
        chk_ids("post_rst", '{0});

        // req1 requests lock with everyone valid; pointer first moved to 1.
        step(4'b0001, 4'h0, 1'b1);
        ids.delete();
        repeat (4) step(4'hF, 4'b0010, 1'b1);
`ifdef FIFO_PUSH_ARBITER_LOCK_EN
        chk_ids("lock", '{1, 1, 1, 2});
`else
        chk_ids("lock", '{1, 2, 3, 0});
`endif
        // Lock released after two beats.
        step(4'b0001, 4'h0, 1'b1);
        ids.delete();
        repeat (2) step(4'hF, 4'b0010, 1'b1);
        repeat (2) step(4'hF, 4'h0, 1'b1);
`ifdef FIFO_PUSH_ARBITER_LOCK_EN
        chk_ids("unlock", '{1, 1, 2});
`else
        chk_ids("unlock", '{1, 2, 3, 0});
`endif

        // Random traffic, locks and drops.
        n_before = ids.size();
        repeat (400) step(NR'($urandom), NR'($urandom), bit'($urandom_range(0, 1)));
        chk("rand_progress", (ids.size() > n_before), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
